// File: rtl/rs_entry.sv
// Single reservation-station slot: latches a dispatched instruction and wakes its operands from the CDB.
// Optional RS_CDB_BYPASS_EN forwards a live CDB match to ready and the operand values in the same cycle.
module rs_entry #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5,
  parameter int unsigned REG_W = 5,
  parameter int unsigned PAY_W = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             clear,
  input  logic [XLEN-1:0]  id_rs1_value,
  input  logic [XLEN-1:0]  id_rs2_value,
  input  logic [REG_W-1:0] id_dest_reg_idx,
  input  logic [PAY_W-1:0] id_payload,
  input  logic [TAG_W-1:0] mt_rs1_tag,
  input  logic [TAG_W-1:0] mt_rs2_tag,
  input  logic             mt_rs1_ready,
  input  logic             mt_rs2_ready,
  input  logic [TAG_W-1:0] rob_entry,
  input  logic [XLEN-1:0]  rob_rs1_value,
  input  logic [XLEN-1:0]  rob_rs2_value,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_value,
  output logic [XLEN-1:0]  entry_rs1_value,
  output logic [XLEN-1:0]  entry_rs2_value,
  output logic [TAG_W-1:0] entry_rs1_tag,
  output logic [TAG_W-1:0] entry_rs2_tag,
  output logic [REG_W-1:0] entry_dest_reg_idx,
  output logic [TAG_W-1:0] entry_rob_tag,
  output logic [PAY_W-1:0] entry_payload,
  output logic             busy,
  output logic             ready
);

  logic             busy_q, busy_d;
  logic [XLEN-1:0]  rs1_value_q, rs1_value_d;
  logic [XLEN-1:0]  rs2_value_q, rs2_value_d;
  logic [TAG_W-1:0] rs1_tag_q, rs1_tag_d;
  logic [TAG_W-1:0] rs2_tag_q, rs2_tag_d;
  logic [REG_W-1:0] dest_q, dest_d;
  logic [TAG_W-1:0] rob_tag_q, rob_tag_d;
  logic [PAY_W-1:0] payload_q, payload_d;

  logic [XLEN-1:0]  disp_rs1_value, disp_rs2_value;
  logic [TAG_W-1:0] disp_rs1_tag, disp_rs2_tag;
  logic             cdb_valid, cdb_hit_rs1, cdb_hit_rs2;

  assign cdb_valid   = (cdb_tag != '0);
  // Stored tag 0 means resolved, so a hit also requires a live broadcast.
  assign cdb_hit_rs1 = cdb_valid && (cdb_tag == rs1_tag_q);
  assign cdb_hit_rs2 = cdb_valid && (cdb_tag == rs2_tag_q);

  // Dispatch-time operand resolution: regfile, ROB, same-cycle CDB, or wait on tag.
  always_comb begin
    disp_rs1_value = '0;
    disp_rs1_tag   = '0;
    if (mt_rs1_tag == '0) begin
      disp_rs1_value = id_rs1_value;
    end else if (mt_rs1_ready) begin
      disp_rs1_value = rob_rs1_value;
    end else if (cdb_tag == mt_rs1_tag) begin
      disp_rs1_value = cdb_value;
    end else begin
      disp_rs1_tag = mt_rs1_tag;
    end
  end

  always_comb begin
    disp_rs2_value = '0;
    disp_rs2_tag   = '0;
    if (mt_rs2_tag == '0) begin
      disp_rs2_value = id_rs2_value;
    end else if (mt_rs2_ready) begin
      disp_rs2_value = rob_rs2_value;
    end else if (cdb_tag == mt_rs2_tag) begin
      disp_rs2_value = cdb_value;
    end else begin
      disp_rs2_tag = mt_rs2_tag;
    end
  end

  always_comb begin
    busy_d      = busy_q;
    rs1_value_d = rs1_value_q;
    rs2_value_d = rs2_value_q;
    rs1_tag_d   = rs1_tag_q;
    rs2_tag_d   = rs2_tag_q;
    dest_d      = dest_q;
    rob_tag_d   = rob_tag_q;
    payload_d   = payload_q;
    if (wr_en) begin
      // A dispatch also wins over clear, allowing back-to-back reuse of the slot.
      busy_d      = 1'b1;
      rs1_value_d = disp_rs1_value;
      rs2_value_d = disp_rs2_value;
      rs1_tag_d   = disp_rs1_tag;
      rs2_tag_d   = disp_rs2_tag;
      dest_d      = id_dest_reg_idx;
      rob_tag_d   = rob_entry;
      payload_d   = id_payload;
    end else if (clear) begin
      busy_d    = 1'b0;
      rs1_tag_d = '0;
      rs2_tag_d = '0;
    end else if (busy_q) begin
      if (cdb_hit_rs1) begin
        rs1_value_d = cdb_value;
        rs1_tag_d   = '0;
      end
      if (cdb_hit_rs2) begin
        rs2_value_d = cdb_value;
        rs2_tag_d   = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q      <= 1'b0;
      rs1_value_q <= '0;
      rs2_value_q <= '0;
      rs1_tag_q   <= '0;
      rs2_tag_q   <= '0;
      dest_q      <= '0;
      rob_tag_q   <= '0;
      payload_q   <= '0;
    end else begin
      busy_q      <= busy_d;
      rs1_value_q <= rs1_value_d;
      rs2_value_q <= rs2_value_d;
      rs1_tag_q   <= rs1_tag_d;
      rs2_tag_q   <= rs2_tag_d;
      dest_q      <= dest_d;
      rob_tag_q   <= rob_tag_d;
      payload_q   <= payload_d;
    end
  end

  assign entry_rs1_tag      = rs1_tag_q;
  assign entry_rs2_tag      = rs2_tag_q;
  assign entry_dest_reg_idx = dest_q;
  assign entry_rob_tag      = rob_tag_q;
  assign entry_payload      = payload_q;
  assign busy               = busy_q;

`ifdef RS_CDB_BYPASS_EN
  assign entry_rs1_value = cdb_hit_rs1 ? cdb_value : rs1_value_q;
  assign entry_rs2_value = cdb_hit_rs2 ? cdb_value : rs2_value_q;
  assign ready = busy_q && ((rs1_tag_q == '0) || cdb_hit_rs1)
                        && ((rs2_tag_q == '0) || cdb_hit_rs2);
`else
  assign entry_rs1_value = rs1_value_q;
  assign entry_rs2_value = rs2_value_q;
  assign ready = busy_q && (rs1_tag_q == '0) && (rs2_tag_q == '0);
`endif

endmodule

// File: tb/tb_rs_entry.sv
// Directed self-checking bench for rs_entry: dispatch resolution, CDB wakeup, clear and reuse.
module tb_rs_entry;

  logic        clock = 1'b0;
  logic        reset, wr_en, clear;
  logic [31:0] id_rs1_value, id_rs2_value;
  logic [4:0]  id_dest_reg_idx;
  logic [63:0] id_payload;
  logic [4:0]  mt_rs1_tag, mt_rs2_tag;
  logic        mt_rs1_ready, mt_rs2_ready;
  logic [4:0]  rob_entry;
  logic [31:0] rob_rs1_value, rob_rs2_value;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic [31:0] entry_rs1_value, entry_rs2_value;
  logic [4:0]  entry_rs1_tag, entry_rs2_tag;
  logic [4:0]  entry_dest_reg_idx, entry_rob_tag;
  logic [63:0] entry_payload;
  logic        busy, ready;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  rs_entry dut (
    .clock              (clock),
    .reset              (reset),
    .wr_en              (wr_en),
    .clear              (clear),
    .id_rs1_value       (id_rs1_value),
    .id_rs2_value       (id_rs2_value),
    .id_dest_reg_idx    (id_dest_reg_idx),
    .id_payload         (id_payload),
    .mt_rs1_tag         (mt_rs1_tag),
    .mt_rs2_tag         (mt_rs2_tag),
    .mt_rs1_ready       (mt_rs1_ready),
    .mt_rs2_ready       (mt_rs2_ready),
    .rob_entry          (rob_entry),
    .rob_rs1_value      (rob_rs1_value),
    .rob_rs2_value      (rob_rs2_value),
    .cdb_tag            (cdb_tag),
    .cdb_value          (cdb_value),
    .entry_rs1_value    (entry_rs1_value),
    .entry_rs2_value    (entry_rs2_value),
    .entry_rs1_tag      (entry_rs1_tag),
    .entry_rs2_tag      (entry_rs2_tag),
    .entry_dest_reg_idx (entry_dest_reg_idx),
    .entry_rob_tag      (entry_rob_tag),
    .entry_payload      (entry_payload),
    .busy               (busy),
    .ready              (ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic dispatch(input logic [4:0] t1, input logic [4:0] t2, input logic r1,
                          input logic r2, input logic [4:0] rob);
    wr_en        = 1'b1;
    mt_rs1_tag   = t1;
    mt_rs2_tag   = t2;
    mt_rs1_ready = r1;
    mt_rs2_ready = r2;
    rob_entry    = rob;
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; clear = 1'b0;
    id_rs1_value = '0; id_rs2_value = '0; id_dest_reg_idx = '0; id_payload = '0;
    mt_rs1_tag = '0; mt_rs2_tag = '0; mt_rs1_ready = 1'b0; mt_rs2_ready = 1'b0;
    rob_entry = '0; rob_rs1_value = '0; rob_rs2_value = '0;
    cdb_tag = '0; cdb_value = '0;
    step();
    step();
    check("rst_busy", busy, 0);
    check("rst_ready", ready, 0);
    check("rst_tag1", entry_rs1_tag, 0);
    check("rst_tag2", entry_rs2_tag, 0);
    check("rst_payload", entry_payload, 0);
    reset = 1'b0;

    // Both operands from the register file.
    id_rs1_value = 32'd1; id_rs2_value = 32'd1; id_dest_reg_idx = 5'd1;
    id_payload = 64'hdead_beef_0000_0001;
    dispatch(5'd0, 5'd0, 1'b0, 1'b0, 5'd1);
    step();
    check("rf_busy", busy, 1);
    check("rf_ready", ready, 1);
    check("rf_v1", entry_rs1_value, 1);
    check("rf_v2", entry_rs2_value, 1);
    check("rf_dest", entry_dest_reg_idx, 1);
    check("rf_rob", entry_rob_tag, 1);
    check("rf_payload", entry_payload, 64'hdead_beef_0000_0001);
    wr_en = 1'b0; clear = 1'b1;
    step();
    check("clr_busy", busy, 0);
    check("clr_ready", ready, 0);
    clear = 1'b0;

    // Both operands from the ROB.
    id_rs1_value = 32'd99; id_rs2_value = 32'd98;
    rob_rs1_value = 32'd5; rob_rs2_value = 32'd6;
    dispatch(5'd1, 5'd1, 1'b1, 1'b1, 5'd2);
    step();
    check("rob_busy", busy, 1);
    check("rob_ready", ready, 1);
    check("rob_v1", entry_rs1_value, 5);
    check("rob_v2", entry_rs2_value, 6);
    check("rob_t1", entry_rs1_tag, 0);
    check("rob_t2", entry_rs2_tag, 0);

    // Both waiting on tag 1, woken together.
    dispatch(5'd1, 5'd1, 1'b0, 1'b0, 5'd3);
    step();
    check("wait_busy", busy, 1);
    check("wait_ready", ready, 0);
    check("wait_t1", entry_rs1_tag, 1);
    check("wait_t2", entry_rs2_tag, 1);
    wr_en = 1'b0; cdb_tag = 5'd1; cdb_value = 32'd1;
    #1;
`ifdef RS_CDB_BYPASS_EN
    check("bypass_ready", ready, 1);
`else
    check("nobypass_ready", ready, 0);
`endif
    step();
    check("wake_ready", ready, 1);
    check("wake_v1", entry_rs1_value, 1);
    check("wake_v2", entry_rs2_value, 1);
    cdb_tag = '0;

    // Tags 3/4 woken one at a time; a foreign tag changes nothing.
    dispatch(5'd3, 5'd4, 1'b0, 1'b0, 5'd4);
    step();
    wr_en = 1'b0; cdb_tag = 5'd4; cdb_value = 32'd10;
    step();
    check("p4_ready", ready, 0);
    check("p4_t2", entry_rs2_tag, 0);
    check("p4_t1", entry_rs1_tag, 3);
    check("p4_v2", entry_rs2_value, 10);
    cdb_tag = 5'd7; cdb_value = 32'd55;
    step();
    check("miss_t1", entry_rs1_tag, 3);
    check("miss_ready", ready, 0);
    cdb_tag = 5'd3; cdb_value = 32'd10;
    step();
    check("p3_ready", ready, 1);
    check("p3_v1", entry_rs1_value, 10);
    check("p3_v2", entry_rs2_value, 10);
    cdb_tag = '0;

    // Clear and dispatch in the same cycle reuses the slot.
    clear = 1'b1; rob_rs1_value = 32'd7; rob_rs2_value = 32'd8;
    dispatch(5'd1, 5'd1, 1'b1, 1'b1, 5'd6);
    step();
    check("reuse_busy", busy, 1);
    check("reuse_rob", entry_rob_tag, 6);
    check("reuse_ready", ready, 1);
    check("reuse_v2", entry_rs2_value, 8);
    clear = 1'b0;

    // rs2 from ROB, rs1 waits through an idle cycle.
    rob_rs2_value = 32'd20;
    dispatch(5'd2, 5'd3, 1'b0, 1'b1, 5'd7);
    step();
    check("mix_ready", ready, 0);
    check("mix_t1", entry_rs1_tag, 2);
    check("mix_v2", entry_rs2_value, 20);
    wr_en = 1'b0;
    step();
    check("idle_ready", ready, 0);
    cdb_tag = 5'd2; cdb_value = 32'd10;
    step();
    check("mix_wake_ready", ready, 1);
    check("mix_wake_v1", entry_rs1_value, 10);

    // CDB matches the waiting tag during the dispatch cycle itself.
    cdb_tag = 5'd5; cdb_value = 32'd33; id_rs2_value = 32'd44;
    dispatch(5'd5, 5'd0, 1'b0, 1'b0, 5'd8);
    step();
    check("fwd_ready", ready, 1);
    check("fwd_v1", entry_rs1_value, 33);
    check("fwd_t1", entry_rs1_tag, 0);
    check("fwd_v2", entry_rs2_value, 44);
    cdb_tag = '0;

    // Repeated dispatch while busy overwrites; then clear drops a pending tag.
    dispatch(5'd9, 5'd0, 1'b0, 1'b0, 5'd9);
    step();
    check("ovw_rob", entry_rob_tag, 9);
    check("ovw_t1", entry_rs1_tag, 9);
    check("ovw_ready", ready, 0);
    wr_en = 1'b0; clear = 1'b1;
    step();
    check("clrw_busy", busy, 0);
    check("clrw_t1", entry_rs1_tag, 0);
    clear = 1'b0;

    // Reset beats a simultaneous dispatch.
    reset = 1'b1;
    dispatch(5'd0, 5'd0, 1'b0, 1'b0, 5'd10);
    step();
    check("rstpri_busy", busy, 0);
    check("rstpri_rob", entry_rob_tag, 0);
    reset = 1'b0; wr_en = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
